// File: rtl/pc_unit_ras.sv
// pc_unit_ras: program counter with stall, exception redirect and a
// return-address stack that cross-checks RET targets.
module pc_unit_ras #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'('h80),
  parameter int RAS_DEPTH = 4,
  localparam int PW = $clog2(RAS_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            pc_control,
  input  logic [25:0]           jump_address,
  input  logic [15:0]           branch_offset,
  input  logic [ADDR_WIDTH-1:0] reg_address,
  input  logic                  stall,
  input  logic                  exc_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [CW-1:0]         ras_count,
  output logic                  ras_mismatch,
  output logic                  misaligned
);
  logic [ADDR_WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] wr_ptr, top_idx;
  logic [31:0] p4w, jt32, br_off;
  logic [ADDR_WIDTH-1:0] jt, bt, rt, next;
  logic is_jump, is_reg, is_push, is_pop;

  assign pc_plus4 = pc + ADDR_WIDTH'(4);
  // widen to 32 bits so the region bits above [27:0] exist for every legal width
  assign p4w = 32'(pc_plus4);
  assign jt32 = {p4w[31:28], jump_address, 2'b00};
  assign jt = jt32[ADDR_WIDTH-1:0];
  assign br_off = {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign bt = pc_plus4 + br_off[ADDR_WIDTH-1:0];
  assign rt = {reg_address[ADDR_WIDTH-1:2], 2'b00};
  assign top_idx = wr_ptr - PW'(1);

  always_comb begin
    is_jump = pc_control == 4'd1 || pc_control == 4'd4;
    is_reg  = pc_control == 4'd3 || pc_control == 4'd5 || pc_control == 4'd6;
    is_push = pc_control == 4'd4 || pc_control == 4'd5;
    is_pop  = pc_control == 4'd6;
    next = is_jump ? jt : pc_control == 4'd2 ? bt : is_reg ? rt : pc_plus4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_VECTOR;
      wr_ptr <= '0;
      ras_count <= '0;
      ras_mismatch <= 1'b0;
      misaligned <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else if (exc_valid) begin
      pc <= EXC_VECTOR;
      wr_ptr <= '0;
      ras_count <= '0;
      ras_mismatch <= 1'b0;
      misaligned <= 1'b0;
    end else if (stall) begin
      ras_mismatch <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      pc <= next;
      misaligned <= is_reg && reg_address[1:0] != 2'b00;
      ras_mismatch <= is_pop && (ras_count == '0 || ras[top_idx] != rt);
      if (is_push) begin
        // a full stack wraps and overwrites its oldest entry
        ras[wr_ptr] <= pc_plus4;
        wr_ptr <= wr_ptr + PW'(1);
        ras_count <= ras_count == CW'(RAS_DEPTH) ? ras_count : ras_count + CW'(1);
      end
      if (is_pop && ras_count != '0) begin
        wr_ptr <= top_idx;
        ras_count <= ras_count - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: directed and randomized checks of pc_unit_ras against a
// queue-based return-stack model.
module tb_pc_unit_ras;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0;
  logic [3:0] pc_control = 0;
  logic [25:0] jump_address = 0;
  logic [15:0] branch_offset = 0;
  logic [31:0] reg_address = 0;
  logic stall = 0, exc_valid = 0;
  logic [31:0] pc, pc_plus4;
  logic [2:0] ras_count;
  logic ras_mismatch, misaligned;

  int errors = 0, checks = 0;
  logic [31:0] m_pc = 0;
  logic [31:0] m_stack[$];
  logic m_mm = 0, m_mis = 0;

  pc_unit_ras #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_control(pc_control), .jump_address(jump_address),
    .branch_offset(branch_offset), .reg_address(reg_address), .stall(stall),
    .exc_valid(exc_valid), .pc(pc), .pc_plus4(pc_plus4), .ras_count(ras_count),
    .ras_mismatch(ras_mismatch), .misaligned(misaligned));

  always #5 clk = ~clk;

  task automatic step(input logic [3:0] c, input logic [25:0] ja, input logic [15:0] bo,
                      input logic [31:0] ra, input logic st, input logic ex);
    logic [31:0] p4, tgt, top;
    pc_control = c; jump_address = ja; branch_offset = bo; reg_address = ra;
    stall = st; exc_valid = ex;
    m_mm = 0; m_mis = 0;
    if (ex) begin
      m_pc = 32'h80;
      m_stack.delete();
    end else if (!st) begin
      p4 = m_pc + 4;
      tgt = ra & ~32'd3;
      if (c == 1 || c == 4) m_pc = (p4 & 32'hF000_0000) | ({6'd0, ja} * 4);
      else if (c == 2) m_pc = p4 + 32'(int'($signed(bo)) * 4);
      else if (c == 3 || c == 5 || c == 6) m_pc = tgt;
      else m_pc = p4;
      if (c == 3 || c == 5 || c == 6) m_mis = ra[1:0] != 0;
      if (c == 4 || c == 5) begin
        m_stack.push_back(p4);
        if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
      end
      if (c == 6) begin
        if (m_stack.size() == 0) m_mm = 1;
        else begin
          top = m_stack.pop_back();
          m_mm = top != tgt;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 0;
    #3;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
    checks++; if (ras_mismatch !== 1'b0 || misaligned !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", ras_mismatch, misaligned); end
    @(posedge clk); #1;
    rst = 1;
    m_pc = 0; m_stack.delete();
  endtask

  task automatic test_seq_branch;
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc got=%h exp=%h", pc, 4 * i); end
    end
    checks++; if (pc_plus4 !== 32'd16) begin errors++; $display("FAIL pc_plus4 got=%h exp=10", pc_plus4); end
    step(2, 0, 16'hFFFE, 0, 0, 0);
    checks++; if (pc !== 32'd8) begin errors++; $display("FAIL branch_back got=%h exp=8", pc); end
  endtask

  task automatic test_jump;
    step(3, 0, 0, 32'h1000_0010, 0, 0);
    step(1, 26'h0000040, 0, 0, 0, 0);
    checks++; if (pc !== 32'h1000_0100) begin errors++; $display("FAIL jump_pc got=%h exp=10000100", pc); end
  endtask

  task automatic test_jal_ret;
    step(3, 0, 0, 32'h20, 0, 0);
    step(4, 26'h10, 0, 0, 0, 0);
    checks++; if (pc !== 32'h40 || ras_count !== 3'd1) begin errors++; $display("FAIL jal_push got pc=%h cnt=%0d exp pc=40 cnt=1", pc, ras_count); end
    step(6, 0, 0, 32'h24, 0, 0);
    checks++; if (pc !== 32'h24 || ras_count !== 3'd0 || ras_mismatch !== 1'b0) begin errors++; $display("FAIL ret_match got pc=%h cnt=%0d mm=%b exp pc=24 cnt=0 mm=0", pc, ras_count, ras_mismatch); end
    step(6, 0, 0, 32'h40, 0, 0);
    checks++; if (pc !== 32'h40 || ras_mismatch !== 1'b1) begin errors++; $display("FAIL ret_empty got pc=%h mm=%b exp pc=40 mm=1", pc, ras_mismatch); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (ras_mismatch !== 1'b0) begin errors++; $display("FAIL mm_one_cycle got=%b exp=0", ras_mismatch); end
  endtask

  task automatic test_overflow;
    step(3, 0, 0, 32'h100, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(4, 26'((i + 1) * 32'h100 >> 2), 0, 0, 0, 0);
      checks++; if (ras_count !== 3'(i > DEPTH ? DEPTH : i)) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", ras_count, i > DEPTH ? DEPTH : i); end
    end
    for (int i = 5; i >= 2; i--) begin
      step(6, 0, 0, 32'(i * 32'h100 + 4), 0, 0);
      checks++; if (ras_mismatch !== 1'b0 || pc !== 32'(i * 32'h100 + 4)) begin errors++; $display("FAIL ovf_ret got mm=%b pc=%h exp mm=0 pc=%h", ras_mismatch, pc, i * 32'h100 + 4); end
    end
    step(6, 0, 0, 32'h104, 0, 0);
    checks++; if (ras_mismatch !== 1'b1 || ras_count !== 3'd0) begin errors++; $display("FAIL ovf_fifth got mm=%b cnt=%0d exp mm=1 cnt=0", ras_mismatch, ras_count); end
  endtask

  task automatic test_jr_misaligned;
    step(3, 0, 0, 32'h123, 0, 0);
    checks++; if (pc !== 32'h120 || misaligned !== 1'b1) begin errors++; $display("FAIL jr_mis got pc=%h mis=%b exp pc=120 mis=1", pc, misaligned); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (misaligned !== 1'b0 || pc !== 32'h124) begin errors++; $display("FAIL mis_clear got pc=%h mis=%b exp pc=124 mis=0", pc, misaligned); end
  endtask

  task automatic test_stall_exc;
    step(4, 26'h40, 0, 0, 0, 0);
    step(4, 26'h80, 0, 0, 1, 0);
    checks++; if (pc !== 32'h100 || ras_count !== 3'd1) begin errors++; $display("FAIL stall_hold got pc=%h cnt=%0d exp pc=100 cnt=1", pc, ras_count); end
    step(6, 0, 0, 32'h3, 1, 0);
    checks++; if (misaligned !== 1'b0 || ras_mismatch !== 1'b0) begin errors++; $display("FAIL stall_flags got mis=%b mm=%b exp 00", misaligned, ras_mismatch); end
    step(4, 0, 0, 0, 1, 1);
    checks++; if (pc !== 32'h80 || ras_count !== 3'd0) begin errors++; $display("FAIL exc_redirect got pc=%h cnt=%0d exp pc=80 cnt=0", pc, ras_count); end
  endtask

  task automatic test_async_reset;
    step(0, 0, 0, 0, 0, 0);
    #2 rst = 0;
    #1;
    checks++; if (pc !== 32'h0 || ras_count !== 3'd0) begin errors++; $display("FAIL async_rst got pc=%h cnt=%0d exp 0", pc, ras_count); end
    #1 rst = 1;
    m_pc = 0; m_stack.delete(); m_mm = 0; m_mis = 0;
    step(0, 0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL post_rst got=%h exp=4", pc); end
  endtask

  task automatic test_random;
    logic [31:0] ra;
    logic [3:0] c;
    for (int n = 0; n < 400; n++) begin
      c = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) c = 4'($urandom_range(4, 6));
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 0;
      if (m_stack.size() > 0 && $urandom_range(0, 1) == 1) ra = m_stack[$];
      step(c, 26'($urandom), 16'($urandom), ra, $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0);
      checks++;
      if (pc !== m_pc || ras_count !== 3'(m_stack.size()) || ras_mismatch !== m_mm || misaligned !== m_mis || pc_plus4 !== m_pc + 4) begin
        errors++;
        $display("FAIL random[%0d] got pc=%h cnt=%0d mm=%b mis=%b exp pc=%h cnt=%0d mm=%b mis=%b", n, pc, ras_count, ras_mismatch, misaligned, m_pc, m_stack.size(), m_mm, m_mis);
      end
    end
  endtask

  initial begin
    test_reset;
    test_seq_branch;
    test_jump;
    test_jal_ret;
    test_overflow;
    test_jr_misaligned;
    test_stall_exc;
    test_async_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised successor to the single-cycle program counter: computes the next PC from sequential, jump, branch, register, link and return modes.
- Adds stall, an exception redirect and a configurable-depth return-address stack (RAS) that cross-checks return targets.
- Sits between control_unit (pc_control) and instruction_memory (pc). Serves as the PC stage for the upcoming stall-capable core.

Parameters:
- ADDR_WIDTH, 32, PC width in bits; legal range 28..32.
- RESET_VECTOR, 0, PC value loaded on reset; must be word aligned.
- EXC_VECTOR, 32'h80, PC value loaded on exception redirect; must be word aligned.
- RAS_DEPTH, 4, number of RAS entries; power of two, 2..16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_control  in  4  next-PC mode select; encodings are listed under Behaviour.
- jump_address  in  26  instruction[25:0].
- branch_offset  in  16  instruction[15:0], signed word offset.
- reg_address  in  ADDR_WIDTH  rs register value, used for JR, JALR and RET.
- stall  in  1  hold the PC and the RAS this cycle.
- exc_valid  in  1  exception redirect request.
- pc  out  ADDR_WIDTH  current PC (registered).
- pc_plus4  out  ADDR_WIDTH  pc+4, combinational.
- ras_count  out  log2(RAS_DEPTH)+1  number of valid RAS entries (registered).
- ras_mismatch  out  1  one-cycle pulse: a RET found the RAS empty, or the RAS top did not equal the target.
- misaligned  out  1  one-cycle pulse: a register target had bits[1:0] != 0.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_VECTOR.
  - ras_count=0; all RAS entries 0.
  - ras_mismatch=0, misaligned=0.
- All address arithmetic is modulo 2^ADDR_WIDTH.
- Let p4 = pc+4.
- pc_control encodings:
  - 0 SEQ: next = p4.
  - 1 JUMP: next = {p4[AW-1:28], jump_address, 2'b00}.
  - 2 BRANCH: next = p4 + (sign_extend(branch_offset) << 2).
  - 3 JR: next = reg_address & ~3.
  - 4 JAL: target as JUMP; push p4.
  - 5 JALR: target as JR; push p4.
  - 6 RET: target as JR; pop the RAS.
  - 7..15: treated as SEQ. No RAS effect, no flags.
- Latency: next is loaded into pc on the same edge; no extra pipeline stage.
- Push:
  - Write to entry[wr_ptr], then advance wr_ptr with wrap at RAS_DEPTH.
  - ras_count increments, saturating at RAS_DEPTH.
  - When full, a push overwrites the oldest entry.
- Pop:
  - If ras_count>0: compare entry[wr_ptr-1] with the masked target, move wr_ptr back one, ras_count decrements. ras_mismatch=1 on the next cycle if the values differ.
  - If ras_count==0: ras_mismatch=1; pointer and count are unchanged.
  - The architectural target is always reg_address; the RAS never changes the PC.
- misaligned: registered to 1 for one cycle when the mode is 3, 5 or 6, the update is not suppressed, and reg_address[1:0]!=0.
- stall=1 and exc_valid=0:
  - pc, RAS, pointer and count all hold.
  - ras_mismatch and misaligned are 0.
- exc_valid=1 has highest priority and overrides stall:
  - pc=EXC_VECTOR.
  - RAS flushed: ras_count=0, wr_ptr=0; entry contents are don't-care.
  - No flags are raised.
- Flag pulses last exactly one cycle and clear on the following non-flag cycle.
- Reset asserted mid-operation aborts any update immediately; the first edge after rst deasserts performs a normal update.

Test Plan:
1. Reset with RESET_VECTOR=0; release; SEQ for 3 cycles -> pc = 0, 4, 8, 12. Then BRANCH with offset 16'hFFFE at pc=12 -> pc=8.
2. JUMP at pc=32'h1000_0010 with jump_address=26'h0000040 -> pc=32'h1000_0100.
3. JAL at pc=0x20 -> pc=jump target, ras_count=1. RET with reg_address=0x24 -> pc=0x24, ras_count=0, ras_mismatch=0. A second RET with reg_address=0x40 -> ras_mismatch=1 for one cycle, pc=0x40.
4. Five JALs with RAS_DEPTH=4 at pcs 0x100, 0x200, 0x300, 0x400, 0x500 -> ras_count stays 4. Four RETs with the matching targets 0x504, 0x404, 0x304, 0x204 -> no mismatch. A fifth RET -> ras_mismatch=1.
5. JR with reg_address=0x0000_0123 -> pc=0x120, misaligned pulses for one cycle.
6. stall=1 with pc_control=JAL -> pc and ras_count unchanged. stall=1 and exc_valid=1 together -> pc=0x80, ras_count=0. Async rst pulse mid-cycle -> pc=0 immediately.
